// File: rtl/alu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// alu_frame_sequencer
//
// Front end for the combinational ALU. Collects a three-byte frame
// (operand 1, operand 2, opcode) from a valid/ready byte stream, drives the
// registered operands/opcode into the ALU, samples the ALU result one cycle
// later and offers it on a valid/ready result port.
//
// Optional feature macro: OPCODE_CHECK_EN
//   defined   : an opcode outside the supported set yields RES_DATA = 0 and
//               ERR = 1 for that result (cleared on the result handshake).
//   undefined : ERR is tied low and every opcode returns ALU_OUT.
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   IN_DATA    in   frame byte
//   IN_VALID   in   IN_DATA valid
//   IN_READY   out  byte accepted this cycle (GET_* states, reset released)
//   OP1/OP2    out  registered ALU operands
//   OPCODE     out  registered ALU opcode (low OPCODE_BUS bits of the byte)
//   ALU_OUT    in   combinational ALU result
//   RES_DATA   out  captured result
//   RES_VALID  out  RES_DATA valid
//   RES_READY  in   consumer accepts result
//   ERR        out  unsupported-opcode flag
// -----------------------------------------------------------------------------
module alu_frame_sequencer #(
  parameter int DATA_BUS   = 8,
  parameter int OPCODE_BUS = 6
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_BUS-1:0]   IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_BUS-1:0]   OP1,
  output logic [DATA_BUS-1:0]   OP2,
  output logic [OPCODE_BUS-1:0] OPCODE,
  input  logic [DATA_BUS-1:0]   ALU_OUT,
  output logic [DATA_BUS-1:0]   RES_DATA,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    ST_GET_OP1 = 3'd0,
    ST_GET_OP2 = 3'd1,
    ST_GET_OPC = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_get_state;
  logic [DATA_BUS-1:0]   r_op1;
  logic [DATA_BUS-1:0]   r_op2;
  logic [OPCODE_BUS-1:0] r_opcode;
  logic [DATA_BUS-1:0]   r_res_data;
  logic                  r_res_valid;

`ifdef OPCODE_CHECK_EN
  localparam logic [OPCODE_BUS-1:0] OPC_ADD = OPCODE_BUS'(6'b100000);
  localparam logic [OPCODE_BUS-1:0] OPC_SUB = OPCODE_BUS'(6'b100010);
  localparam logic [OPCODE_BUS-1:0] OPC_AND = OPCODE_BUS'(6'b100100);
  localparam logic [OPCODE_BUS-1:0] OPC_OR  = OPCODE_BUS'(6'b100101);
  localparam logic [OPCODE_BUS-1:0] OPC_XOR = OPCODE_BUS'(6'b100110);
  localparam logic [OPCODE_BUS-1:0] OPC_SRA = OPCODE_BUS'(6'b000011);
  localparam logic [OPCODE_BUS-1:0] OPC_SRL = OPCODE_BUS'(6'b000010);
  localparam logic [OPCODE_BUS-1:0] OPC_NOR = OPCODE_BUS'(6'b100111);

  logic r_err;

  // Membership test against the set of opcodes the ALU implements.
  function automatic logic opcode_supported(input logic [OPCODE_BUS-1:0] opc);
    logic ok;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_SRA, OPC_SRL, OPC_NOR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // The byte port is open only while collecting a frame; during reset the
  // state already reads GET_OP1, so RST_N gates it explicitly.
  assign w_get_state = (r_state == ST_GET_OP1) || (r_state == ST_GET_OP2) ||
                       (r_state == ST_GET_OPC);
  assign IN_READY    = w_get_state & RST_N;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_GET_OP1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode. IN_READY is 1 in every GET_* state while out of
  // reset, so IN_VALID alone marks a transfer there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_GET_OP1: begin
        if (IN_VALID) w_state_nxt = ST_GET_OP2;
        else          w_state_nxt = ST_GET_OP1;
      end
      ST_GET_OP2: begin
        if (IN_VALID) w_state_nxt = ST_GET_OPC;
        else          w_state_nxt = ST_GET_OP2;
      end
      ST_GET_OPC: begin
        if (IN_VALID) w_state_nxt = ST_EXEC;
        else          w_state_nxt = ST_GET_OPC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (RES_READY) w_state_nxt = ST_GET_OP1;
        else           w_state_nxt = ST_SEND;
      end
      default: begin
        w_state_nxt = ST_GET_OP1;
      end
    endcase
  end

  // Frame capture, result capture and result handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_opcode    <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
`ifdef OPCODE_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_GET_OP1: begin
          if (IN_VALID) r_op1 <= IN_DATA;
        end
        ST_GET_OP2: begin
          if (IN_VALID) r_op2 <= IN_DATA;
        end
        ST_GET_OPC: begin
          // Upper byte bits beyond the opcode width are ignored.
          if (IN_VALID) r_opcode <= IN_DATA[OPCODE_BUS-1:0];
        end
        ST_EXEC: begin
          // ALU has had a full cycle to settle on the registered operands.
          r_res_valid <= 1'b1;
`ifdef OPCODE_CHECK_EN
          if (opcode_supported(r_opcode)) begin
            r_res_data <= ALU_OUT;
            r_err      <= 1'b0;
          end else begin
            r_res_data <= '0;
            r_err      <= 1'b1;
          end
`else
          r_res_data <= ALU_OUT;
`endif
        end
        ST_SEND: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
`ifdef OPCODE_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OP1       = r_op1;
  assign OP2       = r_op2;
  assign OPCODE    = r_opcode;
  assign RES_DATA  = r_res_data;
  assign RES_VALID = r_res_valid;
`ifdef OPCODE_CHECK_EN
  assign ERR       = r_err;
`else
  assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for alu_frame_sequencer with a behavioural ALU attached to
// OP1/OP2/OPCODE/ALU_OUT. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_frame_sequencer;

  logic       CLK;
  logic       RST_N;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] OP1;
  logic [7:0] OP2;
  logic [5:0] OPCODE;
  logic [7:0] ALU_OUT;
  logic [7:0] RES_DATA;
  logic       RES_VALID;
  logic       RES_READY;
  logic       ERR;

  int n_checks;
  int n_pass;
  logic [7:0] res_q[$];

  alu_frame_sequencer #(.DATA_BUS(8), .OPCODE_BUS(6)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_DATA  (IN_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OP1      (OP1),
    .OP2      (OP2),
    .OPCODE   (OPCODE),
    .ALU_OUT  (ALU_OUT),
    .RES_DATA (RES_DATA),
    .RES_VALID(RES_VALID),
    .RES_READY(RES_READY),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU; unknown opcodes return a recognisable 0xEE.
  always_comb begin
    case (OPCODE)
      6'b100000: ALU_OUT = OP1 + OP2;
      6'b100010: ALU_OUT = OP1 - OP2;
      6'b100100: ALU_OUT = OP1 & OP2;
      6'b100101: ALU_OUT = OP1 | OP2;
      6'b100110: ALU_OUT = OP1 ^ OP2;
      6'b000011: ALU_OUT = 8'($signed(OP1) >>> OP2);
      6'b000010: ALU_OUT = OP1 >> OP2;
      6'b100111: ALU_OUT = ~(OP1 | OP2);
      default:   ALU_OUT = 8'hEE;
    endcase
  end

  // Record every result that will be handshaken at the coming rising edge.
  always @(negedge CLK) begin
    if (RES_VALID === 1'b1 && RES_READY === 1'b1) res_q.push_back(RES_DATA);
  end

  // Present a byte and wait (bounded) for the edge that accepts it.
  // Returns 1 unit after that edge with IN_VALID still asserted.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (IN_READY === 1'b1) done = 1'b1;
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (!done) $display("FAIL send_byte timeout: byte %02h never accepted", b);
    else n_pass++;
  endtask

  task automatic test_reset;
    RST_N     = 1'b1;
    IN_DATA   = 8'h00;
    IN_VALID  = 1'b0;
    RES_READY = 1'b0;
    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({OP1, OP2, OPCODE, RES_DATA, RES_VALID, ERR, IN_READY} !== 41'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {OP1, OP2, OPCODE, RES_DATA, RES_VALID, ERR, IN_READY});
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", IN_READY);
    else n_pass++;
  endtask

  task automatic test_add_latency;
    RES_READY = 1'b1;
    send_byte(8'h02);
    send_byte(8'h08);
    send_byte(8'h20);
    IN_VALID = 1'b0;
    // In EXEC: no result yet, byte port closed.
    n_checks++;
    if ({RES_VALID, IN_READY} !== 2'b00)
      $display("FAIL add_exec_state: valid/ready got %b required 00", {RES_VALID, IN_READY});
    else n_pass++;
    n_checks++;
    if ({OP1, OP2, OPCODE} !== {8'h02, 8'h08, 6'h20})
      $display("FAIL add_operands: got %h required %h", {OP1, OP2, OPCODE}, {8'h02, 8'h08, 6'h20});
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA, ERR} !== {1'b1, 8'h0A, 1'b0})
      $display("FAIL add_result: valid/data/err got %b/%h/%b required 1/0a/0", RES_VALID, RES_DATA, ERR);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, IN_READY} !== 2'b01)
      $display("FAIL add_handshake: valid/ready got %b required 01", {RES_VALID, IN_READY});
    else n_pass++;
  endtask

  task automatic test_backpressure;
    RES_READY = 1'b0;
    send_byte(8'hAF);
    send_byte(8'h03);
    send_byte(8'h03);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({RES_VALID, RES_DATA, IN_READY} !== {1'b1, 8'hF5, 1'b0})
        $display("FAIL sra_hold cycle %0d: valid/data/ready got %b/%h/%b required 1/f5/0",
                 i, RES_VALID, RES_DATA, IN_READY);
      else n_pass++;
      @(posedge CLK);
      #1;
    end
    RES_READY = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, IN_READY} !== 2'b01)
      $display("FAIL sra_release: valid/ready got %b required 01", {RES_VALID, IN_READY});
    else n_pass++;
    send_byte(8'hAF);
    send_byte(8'h03);
    send_byte(8'h02);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 8'h15})
      $display("FAIL srl_result: valid/data got %b/%h required 1/15", RES_VALID, RES_DATA);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back;
    res_q.delete();
    RES_READY = 1'b1;
    send_byte(8'h13);
    send_byte(8'h04);
    send_byte(8'h22);
    send_byte(8'h1E);
    send_byte(8'h07);
    send_byte(8'h27);
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (res_q.size() !== 2)
      $display("FAIL stream_count: got %0d results required 2", res_q.size());
    else n_pass++;
    if (res_q.size() == 2) begin
      n_checks++;
      if ({res_q[0], res_q[1]} !== {8'h0F, 8'hE0})
        $display("FAIL stream_results: got %h %h required 0f e0", res_q[0], res_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_opcode_upper_bits;
    RES_READY = 1'b1;
    send_byte(8'h13);
    send_byte(8'h04);
    send_byte(8'hE2);
    IN_VALID = 1'b0;
    n_checks++;
    if (OPCODE !== 6'h22) $display("FAIL opc_truncate: opcode got %h required 22", OPCODE);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 8'h0F})
      $display("FAIL opc_sub_result: valid/data got %b/%h required 1/0f", RES_VALID, RES_DATA);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_midframe_reset;
    RES_READY = 1'b1;
    send_byte(8'h55);
    IN_DATA = 8'h66;
    RST_N   = 1'b0;
    #1;
    n_checks++;
    if ({OP1, OP2, OPCODE, RES_DATA, RES_VALID, ERR, IN_READY} !== 41'd0)
      $display("FAIL midframe_reset: got %h required 0",
               {OP1, OP2, OPCODE, RES_DATA, RES_VALID, ERR, IN_READY});
    else n_pass++;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST_N    = 1'b1;
    @(posedge CLK);
    #1;
    send_byte(8'h21);
    send_byte(8'h0A);
    send_byte(8'h25);
    IN_VALID = 1'b0;
    n_checks++;
    if ({OP1, OP2} !== {8'h21, 8'h0A})
      $display("FAIL post_reset_operands: got %h required 210a", {OP1, OP2});
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA} !== {1'b1, 8'h2B})
      $display("FAIL post_reset_result: valid/data got %b/%h required 1/2b", RES_VALID, RES_DATA);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_unsupported_opcode;
    logic [8:0] exp_data_err;
`ifdef OPCODE_CHECK_EN
    exp_data_err = {8'h00, 1'b1};
`else
    exp_data_err = {8'hEE, 1'b0};
`endif
    RES_READY = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h3F);
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA, ERR} !== {1'b1, exp_data_err})
      $display("FAIL bad_opcode: valid/data/err got %b/%h/%b required 1/%h/%b",
               RES_VALID, RES_DATA, ERR, exp_data_err[8:1], exp_data_err[0]);
    else n_pass++;
    RES_READY = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, ERR, IN_READY} !== 3'b001)
      $display("FAIL bad_opcode_clear: valid/err/ready got %b required 001", {RES_VALID, ERR, IN_READY});
    else n_pass++;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if ({RES_VALID, RES_DATA, ERR} !== {1'b1, 8'h02, 1'b0})
      $display("FAIL after_bad_opcode: valid/data/err got %b/%h/%b required 1/02/0", RES_VALID, RES_DATA, ERR);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_add_latency();
    test_backpressure();
    test_back_to_back();
    test_opcode_upper_bits();
    test_midframe_reset();
    test_unsupported_opcode();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
